// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 keyboard transmitter and receiver.
//   ps2_state_t  - host-to-device transmit FSM states
//   START / STOP - frame bit levels
//   CMD_* / RESP_ACK - common keyboard command and response bytes
//   odd_parity() - parity bit for a frame byte
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam logic START = 1'b0;
    localparam logic STOP  = 1'b1;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    // PS/2 frames carry odd parity: data bits plus parity hold an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// ps2_tx_if: command handshake between a command source and the PS/2 transmitter.
//   tx_valid / tx_data - command byte offered by the master
//   tx_ready           - transmitter idle, offer will be taken
//   busy               - command in flight (used to gate the receiver)
//   done / err         - one-cycle completion / failure pulses
interface ps2_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, busy, done, err
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, busy, done, err
    );
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: conditions one raw PS/2 line (clock or data).
//   clk, rst_n - system clock, asynchronous active-low reset
//   i_pin      - raw open-drain pin level
//   o_level    - synchronized, debounced line level
//   o_fall     - one-cycle strobe when o_level goes from 1 to 0
// A new level is accepted only after it has been seen for FILTER_CYCLES
// consecutive cycles, so short glitches on the cable never reach the FSM.
module ps2_line_sync #(
    parameter int FILTER_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_fall;

    // Reset to the released (high) level so nothing looks like an edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_CYCLES - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_fall  <= r_level;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 command transmitter.
//   CLOCK_50, rst_n      - system clock, asynchronous active-low reset
//   PS2_KBCLK, PS2_KBDAT - raw PS/2 pin levels
//   kbclk_oe, kbdat_oe   - 1 pulls the corresponding pin low, 0 releases it
//   tx (slave)           - tx_valid/tx_data/tx_ready handshake, busy, done, err
// Sequence: inhibit the clock, request-to-send (data low), release the clock,
// then present one bit per device clock falling edge: 8 data bits LSB first,
// odd parity, stop. The device acknowledges by holding data low at the
// eleventh fall; the transfer ends once both lines are released again.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int INHIBIT_CYCLES = 6000,
    parameter int RTS_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 750_000,
    parameter int FILTER_CYCLES  = 16
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic PS2_KBCLK,
    input  logic PS2_KBDAT,
    output logic kbclk_oe,
    output logic kbdat_oe,
    ps2_tx_if.slave tx
);
    localparam int PHASE_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

    if (CLK_HZ <= 0) begin : g_clk_hz_invalid
        $error("ps2_tx: CLK_HZ must be positive");
    end

    ps2_state_t    r_state;
    logic [PW-1:0] r_phase_cnt;
    logic [TW-1:0] r_tmo;
    logic [3:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic          r_kbclk_oe;
    logic          r_kbdat_oe;
    logic          r_done;
    logic          r_err;

    logic w_clk_level;
    logic w_clk_fall;
    logic w_dat_level;
    logic w_dat_fall_unused;
    logic w_accept;
    logic w_tmo_hit;

    // Line conditioning
    ps2_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_sync (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .i_pin   (PS2_KBCLK),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_dat_sync (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .i_pin   (PS2_KBDAT),
        .o_level (w_dat_level),
        .o_fall  (w_dat_fall_unused)
    );

    assign w_accept  = (r_state == IDLE) && tx.tx_valid;
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    // Frame datapath: byte and parity captured on acceptance, shifted per data bit
    always_ff @(posedge CLOCK_50) begin
        if (w_accept) begin
            r_shift  <= tx.tx_data;
            r_parity <= odd_parity(tx.tx_data);
        end else if (r_state == SEND && w_clk_fall && r_bitcnt < 4'd8) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

    // Transfer control FSM
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_phase_cnt <= '0;
            r_tmo       <= '0;
            r_bitcnt    <= '0;
            r_kbclk_oe  <= 1'b0;
            r_kbdat_oe  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            // A done/err pulse is held for one cycle in the finishing state,
            // so tx_ready never coincides with it.
            if (r_done || r_err) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_kbclk_oe <= 1'b0;
                        r_kbdat_oe <= 1'b0;
                        if (w_accept) begin
                            r_state     <= INHIBIT;
                            r_kbclk_oe  <= 1'b1;
                            r_phase_cnt <= '0;
                            r_bitcnt    <= '0;
                        end
                    end
                    INHIBIT: begin
                        if (r_phase_cnt == PW'(INHIBIT_CYCLES - 1)) begin
                            r_state     <= RTS;
                            r_kbdat_oe  <= ~START;
                            r_phase_cnt <= '0;
                        end else begin
                            r_phase_cnt <= r_phase_cnt + PW'(1);
                        end
                    end
                    RTS: begin
                        if (r_phase_cnt == PW'(RTS_CYCLES - 1)) begin
                            r_state    <= SEND;
                            r_kbclk_oe <= 1'b0;
                            r_tmo      <= '0;
                        end else begin
                            r_phase_cnt <= r_phase_cnt + PW'(1);
                        end
                    end
                    SEND: begin
                        if (w_clk_fall) begin
                            r_tmo    <= '0;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt < 4'd8) begin
                                r_kbdat_oe <= ~r_shift[0];
                            end else if (r_bitcnt == 4'd8) begin
                                r_kbdat_oe <= ~r_parity;
                            end else begin
                                r_kbdat_oe <= ~STOP;
                                r_state    <= ACK;
                            end
                        end else if (w_tmo_hit) begin
                            r_kbclk_oe <= 1'b0;
                            r_kbdat_oe <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_tmo <= r_tmo + TW'(1);
                        end
                    end
                    ACK: begin
                        if (w_clk_fall) begin
                            r_tmo <= '0;
                            if (!w_dat_level) begin
                                r_state <= WAIT_IDLE;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else if (w_tmo_hit) begin
                            r_kbclk_oe <= 1'b0;
                            r_kbdat_oe <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_tmo <= r_tmo + TW'(1);
                        end
                    end
                    WAIT_IDLE: begin
                        if (w_clk_level && w_dat_level) begin
                            r_done <= 1'b1;
                        end else if (w_clk_fall) begin
                            r_tmo <= '0;
                        end else if (w_tmo_hit) begin
                            r_kbclk_oe <= 1'b0;
                            r_kbdat_oe <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_tmo <= r_tmo + TW'(1);
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_kbclk_oe <= 1'b0;
                        r_kbdat_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign kbclk_oe    = r_kbclk_oe;
    assign kbdat_oe    = r_kbdat_oe;
    assign tx.tx_ready = (r_state == IDLE);
    assign tx.busy     = (r_state != IDLE);
    assign tx.done     = r_done;
    assign tx.err      = r_err;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed bench for ps2_tx with a PS/2 keyboard model that
// clocks the frame in, records every bit and optionally acknowledges.
module tb_ps2_tx;
    localparam int INH  = 60;
    localparam int RTSC = 20;
    localparam int TMO  = 2000;
    localparam int FILT = 16;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic rst_n;
    logic dev_clk_low;
    logic dev_dat_low;
    logic kbclk_oe;
    logic kbdat_oe;
    logic ps2_clk_pin;
    logic ps2_dat_pin;

    // Open-drain lines: low if either side pulls
    assign ps2_clk_pin = ~kbclk_oe & ~dev_clk_low;
    assign ps2_dat_pin = ~kbdat_oe & ~dev_dat_low;

    ps2_tx_if bus ();

    ps2_tx #(
        .CLK_HZ         (50_000_000),
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTSC),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_CYCLES  (FILT)
    ) dut (
        .CLOCK_50  (clk),
        .rst_n     (rst_n),
        .PS2_KBCLK (ps2_clk_pin),
        .PS2_KBDAT (ps2_dat_pin),
        .kbclk_oe  (kbclk_oe),
        .kbdat_oe  (kbdat_oe),
        .tx        (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int excl_viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.err)  err_cnt  <= err_cnt + 1;
        if ((bus.done && bus.err) || ((bus.done || bus.err) && bus.tx_ready))
            excl_viol <= excl_viol + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_release(output int cr, output bit ok);
        ok = 1'b0;
        cr = 0;
        for (int w = 0; w < 1000; w++) begin
            if (!kbclk_oe && bus.busy) begin
                ok = 1'b1;
                cr = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 3000; w++) begin
            @(negedge clk);
            if (bus.tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Keyboard model: waits for request-to-send, then generates nclk clocks,
    // sampling data at the end of each high phase (start, d0..d7, parity, stop).
    task automatic dev_run(input int nclk, input bit ack, input bit glitch,
                           output logic [10:0] bits, output bit ok);
        bits = '0;
        ok   = 1'b0;
        for (int w = 0; w < 2000; w++) begin
            @(negedge clk);
            if (ps2_clk_pin && !ps2_dat_pin) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        for (int i = 0; i < nclk; i++) begin
            if (glitch && i == 4) begin
                repeat (10) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (10) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (HALF - 20) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            bits[i] = ps2_dat_pin;
            if (i == 10 && ack) begin
                dev_dat_low = 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        if (ack && nclk == 11) begin
            repeat (HALF) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        dev_clk_low  = 1'b0;
        dev_dat_low  = 1'b0;
        repeat (5) @(negedge clk);
        tests++; if (kbclk_oe !== 1'b0) begin fails++; $display("FAIL rst_kbclk_oe: got %b expected 0", kbclk_oe); end
        tests++; if (kbdat_oe !== 1'b0) begin fails++; $display("FAIL rst_kbdat_oe: got %b expected 0", kbdat_oe); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b expected 0", bus.done); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b expected 0", bus.err); end
        tests++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL rst_tx_ready: got %b expected 1", bus.tx_ready); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_send(input string nm, input logic [7:0] b, input logic exp_par,
                             input bit glitch);
        logic [10:0] bits;
        bit ok;
        int ca, cr, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(b);
        ca = cyc;
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL %s_busy_after_accept: got %b expected 1", nm, bus.busy); end
        tests++; if (kbclk_oe !== 1'b1) begin fails++; $display("FAIL %s_inhibit: got %b expected 1", nm, kbclk_oe); end
        tests++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL %s_ready_low: got %b expected 0", nm, bus.tx_ready); end
        wait_release(cr, ok);
        tests++; if (!ok || (cr - ca) != INH + RTSC) begin
            fails++; $display("FAIL %s_release_time: got %0d expected %0d", nm, cr - ca, INH + RTSC);
        end
        dev_run(11, 1'b1, glitch, bits, ok);
        tests++; if (!ok) begin fails++; $display("FAIL %s_rts_seen: got 0 expected 1", nm); end
        tests++; if (bits[0] !== 1'b0) begin fails++; $display("FAIL %s_start: got %b expected 0", nm, bits[0]); end
        tests++; if (bits[8:1] !== b) begin fails++; $display("FAIL %s_byte: got %h expected %h", nm, bits[8:1], b); end
        tests++; if (bits[9] !== exp_par) begin fails++; $display("FAIL %s_parity: got %b expected %b", nm, bits[9], exp_par); end
        tests++; if (bits[10] !== 1'b1) begin fails++; $display("FAIL %s_stop: got %b expected 1", nm, bits[10]); end
        wait_idle(ok);
        tests++; if (!ok) begin fails++; $display("FAIL %s_back_to_idle: got 0 expected 1", nm); end
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL %s_done_count: got %0d expected 1", nm, done_cnt - d0); end
        tests++; if (err_cnt - e0 != 0) begin fails++; $display("FAIL %s_err_count: got %0d expected 0", nm, err_cnt - e0); end
    endtask

    task automatic test_no_ack();
        logic [10:0] bits;
        bit ok;
        int cr, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hF4);
        wait_release(cr, ok);
        dev_run(11, 1'b0, 1'b0, bits, ok);
        wait_idle(ok);
        repeat (2) @(negedge clk);
        tests++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL noack_err_count: got %0d expected 1", err_cnt - e0); end
        tests++; if (done_cnt - d0 != 0) begin fails++; $display("FAIL noack_done_count: got %0d expected 0", done_cnt - d0); end
        tests++; if (kbclk_oe !== 1'b0 || kbdat_oe !== 1'b0) begin
            fails++; $display("FAIL noack_lines: got %b%b expected 00", kbclk_oe, kbdat_oe);
        end
        tests++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL noack_ready: got %b expected 1", bus.tx_ready); end
    endtask

    task automatic test_timeout();
        bit ok;
        int cr, te;
        te = -1;
        start_tx(8'hFF);
        wait_release(cr, ok);
        for (int w = 0; w < TMO + 500; w++) begin
            @(negedge clk);
            if (bus.err) begin
                te = cyc;
                break;
            end
        end
        tests++; if (!ok || (te - cr) != TMO) begin
            fails++; $display("FAIL timeout_latency: got %0d expected %0d", te - cr, TMO);
        end
        tests++; if (kbclk_oe !== 1'b0 || kbdat_oe !== 1'b0) begin
            fails++; $display("FAIL timeout_lines: got %b%b expected 00", kbclk_oe, kbdat_oe);
        end
        @(negedge clk);
        tests++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL timeout_ready: got %b expected 1", bus.tx_ready); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] bits;
        bit ok;
        int cr, d0, e0;
        start_tx(8'hED);
        wait_release(cr, ok);
        dev_run(5, 1'b0, 1'b0, bits, ok);
        repeat (30) @(negedge clk);
        // after fall 5 the host presents bit4 of 8'hED, which is 0
        tests++; if (kbdat_oe !== 1'b1) begin fails++; $display("FAIL midrst_bit4_driven: got %b expected 1", kbdat_oe); end
        d0 = done_cnt;
        e0 = err_cnt;
        #2 rst_n = 1'b0;
        #1;
        tests++; if (kbclk_oe !== 1'b0 || kbdat_oe !== 1'b0) begin
            fails++; $display("FAIL midrst_async_release: got %b%b expected 00", kbclk_oe, kbdat_oe);
        end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (done_cnt != d0 || err_cnt != e0) begin
            fails++; $display("FAIL midrst_no_pulse: got %0d/%0d expected 0/0", done_cnt - d0, err_cnt - e0);
        end
        d0 = done_cnt;
        start_tx(8'hF4);
        wait_release(cr, ok);
        dev_run(11, 1'b1, 1'b0, bits, ok);
        wait_idle(ok);
        tests++; if (bits[8:1] !== 8'hF4) begin fails++; $display("FAIL midrst_f4_byte: got %h expected f4", bits[8:1]); end
        tests++; if (bits[9] !== 1'b0) begin fails++; $display("FAIL midrst_f4_parity: got %b expected 0", bits[9]); end
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL midrst_f4_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits;
        bit ok;
        bit rel_ok;
        int cr, d0;
        d0 = done_cnt;
        start_tx(8'hED);
        bits = '0;
        ok = 1'b0;
        rel_ok = 1'b0;
        fork
            begin
                @(negedge clk);
                bus.tx_valid = 1'b1;
                bus.tx_data  = 8'h55;
                repeat (300) @(negedge clk);
                bus.tx_valid = 1'b0;
            end
            begin
                wait_release(cr, rel_ok);
                dev_run(11, 1'b1, 1'b0, bits, ok);
            end
        join
        wait_idle(ok);
        tests++; if (bits[8:1] !== 8'hED) begin fails++; $display("FAIL busy_ignore_byte: got %h expected ed", bits[8:1]); end
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL busy_ignore_done: got %0d expected 1", done_cnt - d0); end
        repeat (200) @(negedge clk);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL busy_ignore_no_second: got %b expected 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_send("ed", 8'hED, 1'b1, 1'b0);
        test_send("zero", 8'h00, 1'b1, 1'b0);
        test_send("ff", 8'hFF, 1'b1, 1'b0);
        test_no_ack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_send("glitch", 8'h07, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        tests++; if (excl_viol != 0) begin fails++; $display("FAIL pulse_exclusive: got %0d expected 0", excl_viol); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
